// File: rtl/bram_arbiter.sv
// Arbitrates NUM_CH level-held requests onto one single-port BRAM; grant/BRAM drive are same-cycle combinational,
// read data returns READ_LAT+1 cycles after grant; no backpressure, losing channels simply keep holding their request.
module bram_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int RR_MODE  = 1
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic [NUM_CH*ADDR_W-1:0]   I_ADDR,
  input  logic [NUM_CH*DATA_W-1:0]   I_WDATA,
  input  logic [NUM_CH-1:0]          I_WE_L,
  input  logic [NUM_CH-1:0]          I_RE_L,
  output logic [NUM_CH-1:0]          O_GRANT,
  output logic [NUM_CH*DATA_W-1:0]   O_RDATA,
  output logic [NUM_CH-1:0]          O_RVALID,
  output logic                       O_BRAM_EN,
  output logic                       O_BRAM_WE,
  output logic [ADDR_W-1:0]          O_BRAM_ADDR,
  output logic [DATA_W-1:0]          O_BRAM_DIN,
  input  logic [DATA_W-1:0]          I_BRAM_DOUT
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]   req;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     win_id;
  logic                win_vld;
  logic                win_wr;
  logic                rd_go;
  logic [READ_LAT-1:0] pipe_vld;
  logic [CH_W-1:0]     pipe_id [READ_LAT];

  assign req = ~I_WE_L | ~I_RE_L;

  // Fixed priority is the round-robin search with the start point pinned at ch0.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    if (!I_RESET) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!win_vld && req[CH_W'(idx)]) begin
          win_vld = 1'b1;
          win_id  = CH_W'(idx);
        end
      end
    end
  end

  assign win_wr    = ~I_WE_L[win_id];
  assign rd_go     = win_vld & ~win_wr;
  assign O_GRANT   = win_vld ? (NUM_CH'(1) << win_id) : '0;
  assign O_BRAM_EN = win_vld;
  assign O_BRAM_WE = win_vld & win_wr;

  // win_id stays 0 when idle, so the idle BRAM bus carries ch0's fields.
  always_comb begin
    O_BRAM_ADDR = I_ADDR[ADDR_W-1:0];
    O_BRAM_DIN  = I_WDATA[DATA_W-1:0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (win_id == CH_W'(i)) begin
        O_BRAM_ADDR = I_ADDR[i*ADDR_W +: ADDR_W];
        O_BRAM_DIN  = I_WDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      rr_ptr <= '0;
    end else if (win_vld) begin
      rr_ptr <= (win_id == CH_W'(NUM_CH - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    pipe_id[0] <= win_id;
    for (int s = 1; s < READ_LAT; s++) begin
      pipe_id[s] <= pipe_id[s-1];
    end
  end

  // Last pipe stage lines up with BRAM dout; capturing it here adds the final cycle of latency.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      pipe_vld <= '0;
      O_RVALID <= '0;
      O_RDATA  <= '0;
    end else begin
      pipe_vld[0] <= rd_go;
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
      end
      O_RVALID <= pipe_vld[READ_LAT-1] ? (NUM_CH'(1) << pipe_id[READ_LAT-1]) : '0;
      if (pipe_vld[READ_LAT-1]) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pipe_id[READ_LAT-1] == CH_W'(i)) begin
            O_RDATA[i*DATA_W +: DATA_W] <= I_BRAM_DOUT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench: three arbiter configurations (2ch fixed/lat1, 4ch RR/lat1, 2ch RR/lat2), each on a write-first BRAM model.
module tb_bram_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u_fix: NUM_CH=2, READ_LAT=1, RR_MODE=0
  logic [31:0] f_addr;
  logic [15:0] f_wdata;
  logic [1:0]  f_we_l, f_re_l, f_grant, f_rvalid;
  logic [15:0] f_rdata;
  logic        f_en, f_we;
  logic [15:0] f_baddr;
  logic [7:0]  f_din, f_dout, f_dq;
  logic [7:0]  f_mem [0:65535];

  // u_rr: NUM_CH=4, READ_LAT=1, RR_MODE=1
  logic [63:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_we_l, r_re_l, r_grant, r_rvalid;
  logic [31:0] r_rdata;
  logic        r_en, r_we;
  logic [15:0] r_baddr;
  logic [7:0]  r_din, r_dout, r_dq;
  logic [7:0]  r_mem [0:65535];

  // u_l2: NUM_CH=2, READ_LAT=2, RR_MODE=1
  logic [31:0] l_addr;
  logic [15:0] l_wdata;
  logic [1:0]  l_we_l, l_re_l, l_grant, l_rvalid;
  logic [15:0] l_rdata;
  logic        l_en, l_we;
  logic [15:0] l_baddr;
  logic [7:0]  l_din, l_dout, l_d1, l_d2;
  logic [7:0]  l_mem [0:65535];

  bram_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .READ_LAT(1), .RR_MODE(0)) u_fix (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(f_addr), .I_WDATA(f_wdata), .I_WE_L(f_we_l), .I_RE_L(f_re_l),
    .O_GRANT(f_grant), .O_RDATA(f_rdata), .O_RVALID(f_rvalid), .O_BRAM_EN(f_en), .O_BRAM_WE(f_we),
    .O_BRAM_ADDR(f_baddr), .O_BRAM_DIN(f_din), .I_BRAM_DOUT(f_dout));

  bram_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .READ_LAT(1), .RR_MODE(1)) u_rr (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(r_addr), .I_WDATA(r_wdata), .I_WE_L(r_we_l), .I_RE_L(r_re_l),
    .O_GRANT(r_grant), .O_RDATA(r_rdata), .O_RVALID(r_rvalid), .O_BRAM_EN(r_en), .O_BRAM_WE(r_we),
    .O_BRAM_ADDR(r_baddr), .O_BRAM_DIN(r_din), .I_BRAM_DOUT(r_dout));

  bram_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .READ_LAT(2), .RR_MODE(1)) u_l2 (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(l_addr), .I_WDATA(l_wdata), .I_WE_L(l_we_l), .I_RE_L(l_re_l),
    .O_GRANT(l_grant), .O_RDATA(l_rdata), .O_RVALID(l_rvalid), .O_BRAM_EN(l_en), .O_BRAM_WE(l_we),
    .O_BRAM_ADDR(l_baddr), .O_BRAM_DIN(l_din), .I_BRAM_DOUT(l_dout));

  // Write-first single-port BRAM models
  always @(posedge clk) begin
    if (f_en) begin
      if (f_we) f_mem[f_baddr] <= f_din;
      f_dq <= f_we ? f_din : f_mem[f_baddr];
    end
  end
  assign f_dout = f_dq;

  always @(posedge clk) begin
    if (r_en) begin
      if (r_we) r_mem[r_baddr] <= r_din;
      r_dq <= r_we ? r_din : r_mem[r_baddr];
    end
  end
  assign r_dout = r_dq;

  always @(posedge clk) begin
    l_d2 <= l_d1;
    if (l_en) begin
      if (l_we) l_mem[l_baddr] <= l_din;
      l_d1 <= l_we ? l_din : l_mem[l_baddr];
    end
  end
  assign l_dout = l_d2;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    f_we_l = 2'b11; f_re_l = 2'b11;
    r_we_l = 4'hF;  r_re_l = 4'hF;
    l_we_l = 2'b11; l_re_l = 2'b11;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    f_addr = '0; f_wdata = '0; r_addr = '0; r_wdata = '0; l_addr = '0; l_wdata = '0;
    f_we_l = 2'b10; f_re_l = 2'b00; r_re_l = 4'h0; l_re_l = 2'b00;
    mid();
    n_checks++; if (f_grant !== 2'b00) begin n_fail++; $display("FAIL rst_f_grant: got %b want 00", f_grant); end
    n_checks++; if (f_en !== 1'b0) begin n_fail++; $display("FAIL rst_f_en: got %b want 0", f_en); end
    n_checks++; if (f_we !== 1'b0) begin n_fail++; $display("FAIL rst_f_we: got %b want 0", f_we); end
    n_checks++; if (r_grant !== 4'h0) begin n_fail++; $display("FAIL rst_r_grant: got %b want 0000", r_grant); end
    n_checks++; if (l_grant !== 2'b00) begin n_fail++; $display("FAIL rst_l_grant: got %b want 00", l_grant); end
    cyc();
    cyc();
    rst = 1'b0;
    idle_all();
    mid();
    n_checks++; if (f_rdata !== 16'h0 || f_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_f_out: rdata %h rvalid %b want 0/0", f_rdata, f_rvalid); end
    n_checks++; if (r_rdata !== 32'h0 || r_rvalid !== 4'h0) begin n_fail++; $display("FAIL rst_r_out: rdata %h rvalid %b want 0/0", r_rdata, r_rvalid); end
    n_checks++; if (l_rdata !== 16'h0 || l_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_l_out: rdata %h rvalid %b want 0/0", l_rdata, l_rvalid); end
    n_checks++; if (f_en !== 1'b0) begin n_fail++; $display("FAIL idle_f_en: got %b want 0", f_en); end
    cyc();
  endtask

  task automatic test_single_read();
    f_addr[15:0] = 16'h1234; f_wdata[7:0] = 8'hA5; f_we_l = 2'b10;
    mid();
    n_checks++; if (f_grant !== 2'b01 || f_we !== 1'b1) begin n_fail++; $display("FAIL sr_wr_grant: grant %b we %b want 01/1", f_grant, f_we); end
    n_checks++; if (f_baddr !== 16'h1234 || f_din !== 8'hA5) begin n_fail++; $display("FAIL sr_wr_bus: addr %h din %h want 1234/a5", f_baddr, f_din); end
    cyc();
    f_we_l = 2'b11; f_re_l = 2'b10;
    mid();
    n_checks++; if (f_grant !== 2'b01 || f_we !== 1'b0 || f_en !== 1'b1) begin n_fail++; $display("FAIL sr_rd_grant: grant %b we %b en %b want 01/0/1", f_grant, f_we, f_en); end
    cyc();
    f_re_l = 2'b11;
    mid();
    n_checks++; if (f_rvalid !== 2'b00) begin n_fail++; $display("FAIL sr_rvalid_t1: got %b want 00", f_rvalid); end
    cyc();
    mid();
    n_checks++; if (f_rvalid !== 2'b01) begin n_fail++; $display("FAIL sr_rvalid_t2: got %b want 01", f_rvalid); end
    n_checks++; if (f_rdata[7:0] !== 8'hA5) begin n_fail++; $display("FAIL sr_rdata: got %h want a5", f_rdata[7:0]); end
    cyc();
    mid();
    n_checks++; if (f_rvalid !== 2'b00) begin n_fail++; $display("FAIL sr_rvalid_t3: got %b want 00", f_rvalid); end
    cyc();
  endtask

  task automatic test_fixed_priority();
    f_addr[31:16] = 16'h0001; f_wdata[15:8] = 8'h5A; f_we_l = 2'b01;
    mid();
    n_checks++; if (f_grant !== 2'b10) begin n_fail++; $display("FAIL fp_ch1_wr: got %b want 10", f_grant); end
    cyc();
    f_we_l = 2'b11; f_re_l = 2'b00; f_addr[15:0] = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      mid();
      n_checks++; if (f_grant !== 2'b01) begin n_fail++; $display("FAIL fp_grant c%0d: got %b want 01", c, f_grant); end
      cyc();
    end
    f_re_l = 2'b01;
    mid();
    n_checks++; if (f_grant !== 2'b10) begin n_fail++; $display("FAIL fp_ch1_rd: got %b want 10", f_grant); end
    cyc();
    f_re_l = 2'b11;
    mid();
    n_checks++; if (f_rvalid !== 2'b01 || f_rdata[7:0] !== 8'hA5) begin n_fail++; $display("FAIL fp_ch0_ret: rvalid %b rdata %h want 01/a5", f_rvalid, f_rdata[7:0]); end
    cyc();
    mid();
    n_checks++; if (f_rvalid !== 2'b10) begin n_fail++; $display("FAIL fp_ch1_rvalid: got %b want 10", f_rvalid); end
    n_checks++; if (f_rdata[15:8] !== 8'h5A) begin n_fail++; $display("FAIL fp_ch1_rdata: got %h want 5a", f_rdata[15:8]); end
    cyc();
  endtask

  task automatic test_simul_we_re();
    f_addr[15:0] = 16'h0042; f_wdata[7:0] = 8'h3C; f_we_l = 2'b10; f_re_l = 2'b10;
    mid();
    n_checks++; if (f_we !== 1'b1 || f_grant !== 2'b01 || f_din !== 8'h3C) begin n_fail++; $display("FAIL wr_both: we %b grant %b din %h want 1/01/3c", f_we, f_grant, f_din); end
    cyc();
    idle_all();
    mid();
    n_checks++; if (f_rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_both_rv1: got %b want 00", f_rvalid); end
    cyc();
    mid();
    n_checks++; if (f_rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_both_rv2: got %b want 00", f_rvalid); end
    n_checks++; if (f_mem[16'h0042] !== 8'h3C) begin n_fail++; $display("FAIL wr_both_mem: got %h want 3c", f_mem[16'h0042]); end
    cyc();
  endtask

  task automatic test_round_robin();
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    // preload through ch3 so the pointer wraps back to 0 before the real test
    for (int i = 0; i < 4; i++) begin
      r_addr[48 +: 16] = 16'(16'h0100 + i); r_wdata[24 +: 8] = 8'(8'hB0 + i); r_we_l = 4'b0111;
      mid();
      n_checks++; if (r_grant !== 4'b1000) begin n_fail++; $display("FAIL rr_preload %0d: got %b want 1000", i, r_grant); end
      cyc();
    end
    r_we_l = 4'hF; r_re_l = 4'h0;
    r_addr = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    for (int c = 0; c < 7; c++) begin
      if (c == 5) r_re_l = 4'hF;
      mid();
      if (c < 5) begin
        n_checks++; if (r_grant !== 4'(1 << seq[c])) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want ch%0d", c, r_grant, seq[c]); end
      end
      if (c >= 2) begin
        n_checks++; if (r_rvalid !== 4'(1 << seq[c-2])) begin n_fail++; $display("FAIL rr_rvalid c%0d: got %b want ch%0d", c, r_rvalid, seq[c-2]); end
        n_checks++; if (r_rdata[seq[c-2]*8 +: 8] !== 8'(8'hB0 + seq[c-2])) begin n_fail++; $display("FAIL rr_rdata c%0d: got %h want %h", c, r_rdata[seq[c-2]*8 +: 8], 8'(8'hB0 + seq[c-2])); end
      end else begin
        n_checks++; if (r_rvalid !== 4'h0) begin n_fail++; $display("FAIL rr_rvalid c%0d: got %b want 0000", c, r_rvalid); end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_read();
    r_re_l = 4'b1101; r_addr[16 +: 16] = 16'h0101;
    mid();
    n_checks++; if (r_grant !== 4'b0010) begin n_fail++; $display("FAIL rm_grant: got %b want 0010", r_grant); end
    cyc();
    rst = 1'b1; r_re_l = 4'h0;
    mid();
    n_checks++; if (r_grant !== 4'h0 || r_en !== 1'b0) begin n_fail++; $display("FAIL rm_in_rst: grant %b en %b want 0000/0", r_grant, r_en); end
    cyc();
    rst = 1'b0;
    mid();
    n_checks++; if (r_grant !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant: got %b want 0001", r_grant); end
    n_checks++; if (r_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_no_rvalid: got %b want 0000", r_rvalid); end
    n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata_clr: got %h want 0", r_rdata); end
    cyc();
    r_re_l = 4'hF;
    mid();
    n_checks++; if (r_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_rv_after: got %b want 0000", r_rvalid); end
    cyc();
    mid();
    n_checks++; if (r_rvalid !== 4'b0001 || r_rdata[7:0] !== 8'hB0) begin n_fail++; $display("FAIL rm_ch0_ret: rvalid %b rdata %h want 0001/b0", r_rvalid, r_rdata[7:0]); end
    cyc();
    mid();
    n_checks++; if (r_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_tail: got %b want 0000", r_rvalid); end
    cyc();
  endtask

  task automatic test_back_to_back();
    l_addr[15:0] = 16'h0010; l_wdata[7:0] = 8'h11; l_we_l = 2'b10;
    mid();
    n_checks++; if (l_grant !== 2'b01 || l_we !== 1'b1) begin n_fail++; $display("FAIL b2b_preload: grant %b we %b want 01/1", l_grant, l_we); end
    cyc();
    l_addr[15:0] = 16'h0011; l_wdata[7:0] = 8'h22;
    cyc();
    l_we_l = 2'b11;
    l_addr[31:16] = 16'h0010; l_re_l = 2'b01;
    mid();
    n_checks++; if (l_grant !== 2'b10 || l_baddr !== 16'h0010) begin n_fail++; $display("FAIL b2b_g1: grant %b addr %h want 10/0010", l_grant, l_baddr); end
    cyc();
    l_re_l = 2'b10; l_addr[15:0] = 16'h0011;
    mid();
    n_checks++; if (l_grant !== 2'b01 || l_baddr !== 16'h0011) begin n_fail++; $display("FAIL b2b_g2: grant %b addr %h want 01/0011", l_grant, l_baddr); end
    n_checks++; if (l_rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_rv_t1: got %b want 00", l_rvalid); end
    cyc();
    l_re_l = 2'b11;
    mid();
    n_checks++; if (l_rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_rv_t2: got %b want 00", l_rvalid); end
    cyc();
    mid();
    n_checks++; if (l_rvalid !== 2'b10 || l_rdata[15:8] !== 8'h11) begin n_fail++; $display("FAIL b2b_rv_t3: rvalid %b rdata %h want 10/11", l_rvalid, l_rdata[15:8]); end
    cyc();
    mid();
    n_checks++; if (l_rvalid !== 2'b01 || l_rdata[7:0] !== 8'h22) begin n_fail++; $display("FAIL b2b_rv_t4: rvalid %b rdata %h want 01/22", l_rvalid, l_rdata[7:0]); end
    n_checks++; if (l_rdata[15:8] !== 8'h11) begin n_fail++; $display("FAIL b2b_hold: got %h want 11", l_rdata[15:8]); end
    cyc();
    mid();
    n_checks++; if (l_rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_rv_t5: got %b want 00", l_rvalid); end
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_simul_we_re();
    test_round_robin();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
